serial_tx_fifo: RTL and testbench

Parametrised UART transmitter for the core's serial subsystem.
- Replaces the single-buffer SBUF transmit path with a write FIFO.
- Configurable data width, FIFO depth and baud divider, with an optional 9th (TB8) bit per frame.
- Adds overflow reporting and back-to-back framing, which the single-buffer path lacks.
- Sits between the SFR write decode (SBUF/SCON) and the serial TX pin mux on P3.1.

---
 rtl/serial_tx_fifo.sv | 175 +++++++++++++++++
 tb/tb_serial_tx_fifo.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_tx_fifo.sv
// serial_tx_fifo: UART transmitter with a write FIFO in front of it.
//   Each write pushes {tb8, data} into a DEPTH-entry FIFO. The frame FSM pops
//   entries and sends start(0), DATA_W data bits LSB first, an optional
//   TB8 bit when mode9 is set, and stop(1). Each bit lasts div+1 clocks.
//   Consecutive queued entries go out with no idle gap between frames.
// Ports:
//   serial_clk_i / serial_reset_i : clock, synchronous active-high reset
//   serial_baud_div_i             : bit period minus one, in clocks
//   serial_mode9_i                : frame carries TB8 after the data bits
//   serial_wr_i, serial_sbuf_tx_i, serial_tb8_i : write strobe and payload
//   serial_ovf_clr_i              : clears the sticky overflow flag
//   serial_tx_o                   : serial line, idle high
//   serial_ti_o                   : one-cycle pulse at the end of each stop bit
//   serial_busy_o                 : frame in progress
//   serial_full_o/_empty_o/_level_o : FIFO status
//   serial_ovf_o                  : sticky flag, a write hit a full FIFO
module serial_tx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int DIV_W  = 16
) (
  input  logic                       serial_clk_i,
  input  logic                       serial_reset_i,
  input  logic [DIV_W-1:0]           serial_baud_div_i,
  input  logic                       serial_mode9_i,
  input  logic                       serial_wr_i,
  input  logic [DATA_W-1:0]          serial_sbuf_tx_i,
  input  logic                       serial_tb8_i,
  input  logic                       serial_ovf_clr_i,
  output logic                       serial_tx_o,
  output logic                       serial_ti_o,
  output logic                       serial_busy_o,
  output logic                       serial_full_o,
  output logic                       serial_empty_o,
  output logic [$clog2(DEPTH+1)-1:0] serial_level_o,
  output logic                       serial_ovf_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);
  localparam int IDX_W = $clog2(DATA_W);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_NINTH, S_STOP} state_t;

  state_t              state_q, state_d;
  logic [DATA_W:0]     mem_q [DEPTH];
  logic [PTR_W-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic                full_q, full_d, empty_q, empty_d, ovf_q, ovf_d;
  logic [DATA_W:0]     frame_q, frame_d;   // {tb8, data} of the frame on the wire
  logic [DATA_W-1:0]   data_d;
  logic [DIV_W-1:0]    div_q, div_d, cnt_q, cnt_d;
  logic                mode9_q, mode9_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                tx_q, tx_d, ti_q, ti_d, busy_q, busy_d;
  logic                push, pop, bit_end;

  always_comb begin
    // Push is gated by the registered full flag, so a same-cycle pop never
    // makes room for a write that arrives while full.
    push    = serial_wr_i && !full_q;
    bit_end = (cnt_q == '0);
    pop     = 1'b0;
    state_d = state_q;
    frame_d = frame_q;
    div_d   = div_q;
    mode9_d = mode9_q;
    idx_d   = idx_q;
    ti_d    = 1'b0;
    cnt_d   = bit_end ? div_q : cnt_q - DIV_W'(1);

    case (state_q)
      S_IDLE: begin
        cnt_d = cnt_q;
        if (!empty_q) pop = 1'b1;
      end
      S_START: if (bit_end) begin
        state_d = S_DATA;
        idx_d   = '0;
      end
      S_DATA: if (bit_end) begin
        if (idx_q == IDX_W'(DATA_W-1)) state_d = mode9_q ? S_NINTH : S_STOP;
        else                           idx_d   = idx_q + IDX_W'(1);
      end
      S_NINTH: if (bit_end) state_d = S_STOP;
      S_STOP: if (bit_end) begin
        ti_d = 1'b1;
        if (!empty_q) pop = 1'b1;   // back-to-back: straight into the next start bit
        else          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Divider and mode are sampled only here, so mid-frame changes wait
    // for the next frame.
    if (pop) begin
      state_d = S_START;
      frame_d = mem_q[rptr_q];
      div_d   = serial_baud_div_i;
      mode9_d = serial_mode9_i;
      cnt_d   = serial_baud_div_i;
    end

    wptr_d  = push ? wptr_q + PTR_W'(1) : wptr_q;
    rptr_d  = pop  ? rptr_q + PTR_W'(1) : rptr_q;
    level_d = level_q;
    if (push && !pop)      level_d = level_q + LVL_W'(1);
    else if (pop && !push) level_d = level_q - LVL_W'(1);
    full_d  = (level_d == LVL_W'(DEPTH));
    empty_d = (level_d == '0);

    ovf_d = ovf_q;
    if (serial_wr_i && full_q) ovf_d = 1'b1;
    else if (serial_ovf_clr_i) ovf_d = 1'b0;

    // Line value is derived from the next state so tx_o is registered yet
    // changes on the same edge as the state.
    data_d = frame_d[DATA_W-1:0];
    busy_d = (state_d != S_IDLE);
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = data_d[idx_d];
      S_NINTH: tx_d = frame_d[DATA_W];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge serial_clk_i) begin
    if (serial_reset_i) begin
      state_q <= S_IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
      frame_q <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      mode9_q <= 1'b0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      ti_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      ovf_q   <= ovf_d;
      frame_q <= frame_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      mode9_q <= mode9_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      ti_q    <= ti_d;
      busy_q  <= busy_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge serial_clk_i) begin
    if (push) mem_q[wptr_q] <= {serial_tb8_i, serial_sbuf_tx_i};
  end

  assign serial_tx_o    = tx_q;
  assign serial_ti_o    = ti_q;
  assign serial_busy_o  = busy_q;
  assign serial_full_o  = full_q;
  assign serial_empty_o = empty_q;
  assign serial_level_o = level_q;
  assign serial_ovf_o   = ovf_q;
endmodule

// File: tb/tb_serial_tx_fifo.sv
// tb_serial_tx_fifo: directed bench for serial_tx_fifo (DATA_W=8, DEPTH=4).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_serial_tx_fifo;
  logic        clk = 1'b0;
  logic        rst, m9, wr, tb8, clr;
  logic [15:0] div;
  logic [7:0]  d;
  logic        tx, ti, busy, full, empty, ovf;
  logic [2:0]  level;

  int checks = 0;
  int errors = 0;

  // Per-cycle capture of the line and ti pulses.
  logic [255:0] txv;
  int           nsamp, ti_cnt, ti_first, ti_last;
  // Expected line waveform being built.
  logic [63:0]  ev;
  int           pos;

  serial_tx_fifo #(.DATA_W(8), .DEPTH(4), .DIV_W(16)) dut (
    .serial_clk_i(clk), .serial_reset_i(rst), .serial_baud_div_i(div),
    .serial_mode9_i(m9), .serial_wr_i(wr), .serial_sbuf_tx_i(d),
    .serial_tb8_i(tb8), .serial_ovf_clr_i(clr), .serial_tx_o(tx),
    .serial_ti_o(ti), .serial_busy_o(busy), .serial_full_o(full),
    .serial_empty_o(empty), .serial_level_o(level), .serial_ovf_o(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chkv(input string tag, input logic [63:0] obs, input logic [63:0] exp, input int n);
    logic [63:0] m;
    m = (64'd1 << n) - 64'd1;
    checks++;
    assert ((obs & m) === (exp & m)) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs & m, exp & m);
    end
  endtask

  task automatic sclr();
    txv = '1; nsamp = 0; ti_cnt = 0; ti_first = -1; ti_last = -1;
  endtask

  task automatic tick_s();
    @(posedge clk); #1;
    if (nsamp < 256) txv[nsamp] = tx;
    if (ti) begin
      if (ti_cnt == 0) ti_first = nsamp;
      ti_last = nsamp;
      ti_cnt++;
    end
    nsamp++;
  endtask

  task automatic eclr();
    ev = '1; pos = 1;
  endtask

  task automatic put(input logic b, input int n);
    for (int i = 0; i < n; i++) begin
      if (pos < 64) ev[pos] = b;
      pos++;
    end
  endtask

  task automatic eframe(input logic [7:0] dd, input logic m, input logic t, input int h);
    put(1'b0, h);
    for (int i = 0; i < 8; i++) put(dd[i], h);
    if (m) put(t, h);
    put(1'b1, h);
  endtask

  logic [7:0] tbl [12];
  int lv [4];
  int olv [6];
  logic ofull [6];
  logic oovf [6];

  initial begin
    tbl = '{8'h01, 8'h80, 8'h5A, 8'hC3, 8'h12, 8'h34, 8'h56, 8'h78, 8'hFE, 8'h7F, 8'h00, 8'hAA};
    lv  = '{1, 1, 2, 3};
    olv = '{1, 1, 2, 3, 4, 4};
    ofull = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    oovf  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    rst = 1'b1; wr = 1'b0; m9 = 1'b0; tb8 = 1'b0; clr = 1'b0; div = 16'd3; d = 8'h00;
    sclr();
    tick_s(); tick_s();
    chk1("rst_tx", tx, 1'b1);   chk1("rst_ti", ti, 1'b0);     chk1("rst_busy", busy, 1'b0);
    chk1("rst_full", full, 1'b0); chk1("rst_empty", empty, 1'b1);
    chkn("rst_level", int'(level), 0); chk1("rst_ovf", ovf, 1'b0);
    rst = 1'b0;
    tick_s();

    // Single frame 0xA5, div=3
    sclr(); wr = 1'b1; d = 8'hA5; tick_s(); wr = 1'b0;
    chk1("t1_empty", empty, 1'b0); chkn("t1_level", int'(level), 1);
    chk1("t1_tx_idle", tx, 1'b1);  chk1("t1_busy0", busy, 1'b0);
    repeat (44) tick_s();
    eclr(); eframe(8'hA5, 1'b0, 1'b0, 4);
    chkv("t1_wave", txv[63:0], ev, 45);
    chkn("t1_ti_cnt", ti_cnt, 1); chkn("t1_ti_at", ti_first, 41);
    chk1("t1_busy_end", busy, 1'b0);

    // Back-to-back 0x00, 0xFF, div=1
    div = 16'd1; sclr();
    wr = 1'b1; d = 8'h00; tick_s(); d = 8'hFF; tick_s(); wr = 1'b0;
    chkn("t2_level", int'(level), 1);
    repeat (44) tick_s();
    eclr(); eframe(8'h00, 1'b0, 1'b0, 2); eframe(8'hFF, 1'b0, 1'b0, 2);
    chkv("t2_wave", txv[63:0], ev, 46);
    chkn("t2_ti_cnt", ti_cnt, 2); chkn("t2_ti_first", ti_first, 21); chkn("t2_ti_last", ti_last, 41);

    // 9-bit mode, mode9 dropped mid-frame
    div = 16'd0; m9 = 1'b1; tb8 = 1'b1; sclr();
    wr = 1'b1; d = 8'h00; tick_s(); wr = 1'b0; tick_s();
    m9 = 1'b0;
    repeat (14) tick_s();
    eclr(); eframe(8'h00, 1'b1, 1'b1, 1);
    chkv("t3_wave", txv[63:0], ev, 16);
    chkn("t3_ti_cnt", ti_cnt, 1); chkn("t3_ti_at", ti_first, 12);
    m9 = 1'b1; tb8 = 1'b0; sclr();
    wr = 1'b1; d = 8'hFF; tick_s(); wr = 1'b0;
    repeat (15) tick_s();
    eclr(); eframe(8'hFF, 1'b1, 1'b0, 1);
    chkv("t3b_wave", txv[63:0], ev, 16);
    chkn("t3b_ti_at", ti_first, 12);
    m9 = 1'b0; tb8 = 1'b0;

    // Overflow: 6 writes with div=15, then set-vs-clear priority
    div = 16'd15; sclr();
    for (int i = 0; i < 6; i++) begin
      wr = 1'b1; d = 8'h11 + 8'(i); tick_s();
      chkn($sformatf("t4_level%0d", i), int'(level), olv[i]);
      chk1($sformatf("t4_full%0d", i), full, ofull[i]);
      chk1($sformatf("t4_ovf%0d", i), ovf, oovf[i]);
    end
    d = 8'h77; clr = 1'b1; tick_s();
    chk1("t4_ovf_set_prio", ovf, 1'b1);
    wr = 1'b0; tick_s(); clr = 1'b0;
    chk1("t4_ovf_clr", ovf, 1'b0);
    repeat (810) tick_s();
    chkn("t4_ti_cnt", ti_cnt, 5); chkn("t4_ti_first", ti_first, 161); chkn("t4_ti_last", ti_last, 801);
    chk1("t4_empty", empty, 1'b1); chk1("t4_busy", busy, 1'b0);

    // Wrap and level: three rounds of four writes at div=0
    div = 16'd0;
    for (int r = 0; r < 3; r++) begin
      sclr();
      for (int i = 0; i < 4; i++) begin
        wr = 1'b1; d = tbl[r*4+i]; tick_s();
        chkn($sformatf("t5_r%0d_level%0d", r, i), int'(level), lv[i]);
        chk1($sformatf("t5_r%0d_empty%0d", r, i), empty, 1'b0);
      end
      wr = 1'b0;
      chk1($sformatf("t5_r%0d_full", r), full, 1'b0);
      repeat (41) tick_s();
      eclr();
      for (int i = 0; i < 4; i++) eframe(tbl[r*4+i], 1'b0, 1'b0, 1);
      chkv($sformatf("t5_r%0d_wave", r), txv[63:0], ev, 45);
      chkn($sformatf("t5_r%0d_ti_cnt", r), ti_cnt, 4);
      chkn($sformatf("t5_r%0d_ti_last", r), ti_last, 41);
      chkn($sformatf("t5_r%0d_level_end", r), int'(level), 0);
      chk1($sformatf("t5_r%0d_empty_end", r), empty, 1'b1);
    end

    // Reset during data bit 3 with two entries queued
    div = 16'd3; sclr();
    wr = 1'b1; d = 8'h96; tick_s(); d = 8'h3C; tick_s(); d = 8'h69; tick_s(); wr = 1'b0;
    chkn("t6_level", int'(level), 2);
    repeat (16) tick_s();
    eclr(); eframe(8'h96, 1'b0, 1'b0, 4);
    chkv("t6_wave_pre", txv[63:0], ev, 19);
    rst = 1'b1; tick_s(); rst = 1'b0;
    chk1("t6_tx", tx, 1'b1); chk1("t6_empty", empty, 1'b1); chkn("t6_level0", int'(level), 0);
    chk1("t6_busy", busy, 1'b0); chk1("t6_ti", ti, 1'b0); chk1("t6_full", full, 1'b0);
    sclr(); repeat (50) tick_s();
    eclr();
    chkn("t6_no_ti", ti_cnt, 0); chkv("t6_idle", txv[63:0], ev, 50);
    sclr(); wr = 1'b1; d = 8'hC3; tick_s(); wr = 1'b0;
    repeat (44) tick_s();
    eclr(); eframe(8'hC3, 1'b0, 1'b0, 4);
    chkv("t6_wave_post", txv[63:0], ev, 45);
    chkn("t6_ti_cnt", ti_cnt, 1); chkn("t6_ti_at", ti_first, 41);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
